// File: rtl/pipe_scheduler.sv
// pipe_scheduler
//   Game-flow controller for the pipe obstacle datapath. Runs the
//   IDLE/RUN/DEAD state machine, gates pipe scrolling, picks a new
//   pseudo-random gap height each time a pipe wraps and counts score as pipes
//   pass the bird.
// Ports
//   clk           system clock
//   Reset         asynchronous reset, active low
//   Button        flap/start button, active low, asynchronous to clk
//   Collide       bird hit pipe or ground, active high, clk-synchronous
//   PipesPosition current pipe x from the pipe drawer
//   PipesLong     gap top y for the pipe drawer
//   Status        1 while pipes may scroll (RUN)
//   ScrollTick    one-clk pulse every TICK_DIV clks
//   Score         pipes passed, saturating at 255
//   State         00 IDLE, 01 RUN, 10 DEAD
module pipe_scheduler #(
  parameter int unsigned   TICK_DIV   = 65536,
  parameter int unsigned   GAP_MIN    = 40,
  parameter int unsigned   GAP_RANGE  = 128,
  parameter int unsigned   INIT_GAP   = 120,
  parameter int unsigned   BIRD_X     = 100,
  parameter int unsigned   PIPE_W     = 90,
  parameter int unsigned   HOLD_TICKS = 64,
  parameter logic [7:0]    LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Button,
  input  logic        Collide,
  input  logic [15:0] PipesPosition,
  output logic [15:0] PipesLong,
  output logic        Status,
  output logic        ScrollTick,
  output logic [7:0]  Score,
  output logic [1:0]  State
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  state_t        r_state;
  logic          r_status;
  logic [7:0]    r_score;
  logic [15:0]   r_pipes_long;
  logic [HW-1:0] r_hold;
  logic [TW-1:0] r_tick_cnt;
  logic          r_tick;
  logic [7:0]    r_lfsr;
  logic          r_btn_sync1;
  logic          r_btn_sync2;
  logic          r_btn_prev;
  logic [15:0]   r_pos_prev;

  logic          w_press;
  logic          w_wrap;
  logic          w_passed;
  logic [15:0]   w_new_gap;

  // Button idles high, so a press is a falling edge of the synchronised level.
  assign w_press = r_btn_prev & ~r_btn_sync2;

  // A pipe leaving the left edge reappears on the right: position jumps up.
  assign w_wrap = (PipesPosition > r_pos_prev);

  // Right edge of the pipe crossed the bird's x between last clk and now.
  assign w_passed = (({1'b0, r_pos_prev} + 17'(PIPE_W)) >= 17'(BIRD_X)) &&
                    (({1'b0, PipesPosition} + 17'(PIPE_W)) < 17'(BIRD_X));

  assign w_new_gap = 16'(GAP_MIN) + {8'd0, (r_lfsr & 8'(GAP_RANGE - 1))};

  // Button synchroniser plus edge register, pipe position history, LFSR.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_btn_sync1 <= 1'b1;
      r_btn_sync2 <= 1'b1;
      r_btn_prev  <= 1'b1;
      r_pos_prev  <= '0;
      r_lfsr      <= LFSR_SEED;
    end else begin
      r_btn_sync1 <= Button;
      r_btn_sync2 <= r_btn_sync1;
      r_btn_prev  <= r_btn_sync2;
      r_pos_prev  <= PipesPosition;
      r_lfsr      <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  // Tick is registered one count early so it is high exactly while the
  // counter holds TICK_DIV-1.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      if (r_tick_cnt == TW'(TICK_DIV - 1)) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
      r_tick <= (r_tick_cnt == TW'(TICK_DIV - 2));
    end
  end

  // Game-flow FSM with registered outputs.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_status     <= 1'b0;
      r_score      <= '0;
      r_pipes_long <= 16'(INIT_GAP);
      r_hold       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            r_state  <= ST_RUN;
            r_status <= 1'b1;
          end else begin
            r_status <= 1'b0;
          end
        end
        ST_RUN: begin
          if (Collide) begin
            // Collision wins over any same-cycle wrap or crossing.
            r_state  <= ST_DEAD;
            r_status <= 1'b0;
            r_hold   <= '0;
          end else begin
            r_status <= 1'b1;
            if (w_wrap) begin
              r_pipes_long <= w_new_gap;
            end
            if (w_passed && (r_score != 8'hFF)) begin
              r_score <= r_score + 8'd1;
            end
          end
        end
        ST_DEAD: begin
          r_status <= 1'b0;
          if (r_tick && (r_hold != HW'(HOLD_TICKS))) begin
            r_hold <= r_hold + 1'b1;
          end
          if (w_press && (r_hold == HW'(HOLD_TICKS))) begin
            r_state      <= ST_IDLE;
            r_score      <= '0;
            r_pipes_long <= 16'(INIT_GAP);
          end
        end
        default: begin
          // Unused encoding recovers to IDLE.
          r_state  <= ST_IDLE;
          r_status <= 1'b0;
        end
      endcase
    end
  end

  assign PipesLong  = r_pipes_long;
  assign Status     = r_status;
  assign ScrollTick = r_tick;
  assign Score      = r_score;
  assign State      = r_state;

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler
//   Directed self-checking bench for pipe_scheduler with TICK_DIV=4 and
//   HOLD_TICKS=4. Inputs change 1 time unit after the rising edge and outputs
//   are sampled at the same point.
module tb_pipe_scheduler;

  logic        clk;
  logic        Reset;
  logic        Button;
  logic        Collide;
  logic [15:0] PipesPosition;
  logic [15:0] PipesLong;
  logic        Status;
  logic        ScrollTick;
  logic [7:0]  Score;
  logic [1:0]  State;

  int n_checks = 0;
  int n_fails  = 0;
  int dead_ticks = 0;
  logic [7:0] m_lfsr;

  pipe_scheduler #(
    .TICK_DIV   (4),
    .HOLD_TICKS (4)
  ) dut (
    .clk           (clk),
    .Reset         (Reset),
    .Button        (Button),
    .Collide       (Collide),
    .PipesPosition (PipesPosition),
    .PipesLong     (PipesLong),
    .Status        (Status),
    .ScrollTick    (ScrollTick),
    .Score         (Score),
    .State         (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: 8-bit, shift left, feedback b7^b5^b4^b3, seed A5.
  always @(posedge clk or negedge Reset) begin
    if (!Reset) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One clock; counts ticks seen while DEAD for hold sequencing.
  task automatic step();
    @(posedge clk);
    #1;
    if (ScrollTick && State == 2'b10) dead_ticks++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int first_tick;
    logic [3:0] tick_pat;
    logic [15:0] exp_gap;

    Reset = 1'b0;
    Button = 1'b1;
    Collide = 1'b0;
    PipesPosition = 16'd1;
    first_tick = -1;

    // 1. Reset state and tick cadence.
    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b1;
    check_eq("rst_state", State, 0);
    check_eq("rst_status", Status, 0);
    check_eq("rst_score", Score, 0);
    check_eq("rst_gap", PipesLong, 120);
    check_eq("rst_tick", ScrollTick, 0);
    for (int i = 1; i <= 6 && first_tick < 0; i++) begin
      step();
      if (ScrollTick) first_tick = i;
    end
    check_eq("tick_first", first_tick, 3);
    tick_pat = '0;
    for (int i = 3; i >= 0; i--) begin
      step();
      tick_pat[i] = ScrollTick;
    end
    check_eq("tick_period", tick_pat, 4'b0001);

    // 2. Start press, then long hold causes nothing further.
    Button = 1'b0;
    steps(3);
    check_eq("start_state", State, 1);
    check_eq("start_status", Status, 1);
    steps(20);
    check_eq("hold_low_state", State, 1);

    // 3. Wrap detection and new gap.
    PipesPosition = 16'd0;
    step();
    check_eq("no_wrap_gap", PipesLong, 120);
    PipesPosition = 16'd640;
    exp_gap = 16'd40 + {8'd0, m_lfsr & 8'd127};
    step();
    check_eq("wrap_gap", PipesLong, exp_gap);
    step();
    check_eq("wrap_gap_hold", PipesLong, exp_gap);

    // 4. Crossing: only the 10->9 step scores.
    PipesPosition = 16'd11;
    step();
    PipesPosition = 16'd10;
    step();
    check_eq("cross_pre", Score, 0);
    PipesPosition = 16'd9;
    step();
    check_eq("cross_score", Score, 1);

    // 5. Collision with a same-cycle crossing.
    PipesPosition = 16'd10;
    step();
    PipesPosition = 16'd9;
    Collide = 1'b1;
    dead_ticks = 0;
    step();
    Collide = 1'b0;
    check_eq("dead_state", State, 2);
    check_eq("dead_status", Status, 0);
    check_eq("dead_score", Score, 1);

    for (int i = 0; i < 40 && dead_ticks < 2; i++) step();
    check_eq("dead_wait2", dead_ticks >= 2, 1);
    Button = 1'b1;
    steps(3);
    Button = 1'b0;
    steps(4);
    check_eq("early_press_ignored", State, 2);
    Button = 1'b1;
    steps(3);
    for (int i = 0; i < 40 && dead_ticks < 4; i++) step();
    check_eq("dead_wait4", dead_ticks >= 4, 1);
    step();
    Button = 1'b0;
    steps(3);
    check_eq("restart_state", State, 0);
    check_eq("restart_score", Score, 0);
    check_eq("restart_gap", PipesLong, 120);
    check_eq("restart_status", Status, 0);

    // Back to RUN, then saturate score.
    Button = 1'b1;
    steps(3);
    Button = 1'b0;
    steps(3);
    check_eq("rerun_state", State, 1);
    for (int i = 0; i < 255; i++) begin
      PipesPosition = 16'd10;
      step();
      PipesPosition = 16'd9;
      step();
    end
    check_eq("score_255", Score, 255);
    PipesPosition = 16'd10;
    step();
    PipesPosition = 16'd9;
    step();
    check_eq("score_sat", Score, 255);

    // 6. Asynchronous reset mid-cycle.
    @(posedge clk);
    #3;
    Reset = 1'b0;
    #1;
    check_eq("async_state", State, 0);
    check_eq("async_status", Status, 0);
    check_eq("async_score", Score, 0);
    check_eq("async_gap", PipesLong, 120);
    #10;
    Reset = 1'b1;
    steps(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
